tl_repeater_monitor: RTL and testbench
======================================

Name: tl_repeater_monitor

Overview:
Synthesizable, parametrised successor to the per-repeater simulation assertion checkers. It watches NUM_CH repeater channels for protocol violations: bad fill state, valid without permit, handshake instability and ready starvation. It raises sticky per-channel error flags, a saturating error counter and a first-error capture for SoC debug. It sits beside the TileLink repeaters and drives a debug status register and an interrupt line. It has no simulation-only $fatal behaviour.

Parameters:
NUM_CH, 2, number of monitored channels (1..16)
STATE_W, 4, width of each channel's repeater state field
STATE_OK, 4'hF, required state value whenever a channel's valid is high
DATA_W, 32, payload width per channel, used for the stability check
TIMEOUT, 1024, stall cycles before a starvation error; 0 disables the check
CNT_W, 8, width of the saturating error counter

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset; assertion is async, deassertion is synchronised externally
bypass  input  1  global mask; when high, no check fires and stall tracking clears
ch_valid  input  NUM_CH  per-channel valid
ch_ready  input  NUM_CH  per-channel ready
ch_allow  input  NUM_CH  per-channel permit; valid is legal only while allow=1
ch_state  input  NUM_CH*STATE_W  packed repeater state, channel i at [i*STATE_W +: STATE_W]
ch_data  input  NUM_CH*DATA_W  packed payload
clear  input  1  synchronous clear of sticky flags, counter and capture
err_sticky  output  NUM_CH*4  sticky flags, channel i at [i*4 +: 4]; bit0 STATE, bit1 PERMIT, bit2 STABLE, bit3 TIMEOUT
err_any  output  1  OR of err_sticky; registered; serves as the interrupt
err_count  output  CNT_W  number of cycles in which at least one new violation fired; saturates
first_valid  output  1  set when first_ch/first_code hold a capture
first_ch  output  max(1,$clog2(NUM_CH))  channel of the first violation
first_code  output  2  code of the first violation; 0 STATE, 1 PERMIT, 2 STABLE, 3 TIMEOUT

Behaviour:
- Reset (reset_n=0, async): every output 0. All stall flags, stall counters and captured data are 0.
- Per-channel combinational violation terms. Each term is also gated by !bypass.
  - STATE: valid && state!=STATE_OK.
  - PERMIT: valid && !allow.
  - STABLE: stalled_q && (!valid || data!=data_q).
  - TIMEOUT: TIMEOUT!=0 && stall_cnt==TIMEOUT-1 && valid && !ready.
- stalled_q/data_q register valid&&!ready and data each cycle. Both clear when bypass=1.
- stall_cnt:
  - increments on valid&&!ready, saturating at TIMEOUT;
  - resets to 0 on !valid, on ready, or on bypass.
  - TIMEOUT fires exactly once per stall episode.
- Outputs are registered: a violation sampled at edge k is visible on the outputs after edge k.
- err_sticky bits set on violation and hold until clear.
- Clear and violation in the same cycle: set wins. The flag shows only the new violation; the counter loads 1; the capture loads the new violation.
- err_count increments by 1 per cycle with any violation. It holds at 2^CNT_W-1.
- First capture:
  - loads only while first_valid=0.
  - Simultaneous violations resolve to the lowest channel, then the lowest code.
- bypass does not clear sticky state, the counter or the capture.
- Reset mid-stall discards the stall; the stall episode restarts after reset.

Test Plan:
- NUM_CH=2; ch1 valid=1, state=4'hE, allow=1 for 1 cycle -> next cycle err_sticky[4]=1, err_any=1, err_count=1, first_ch=1, first_code=0.
- ch0 valid=1, allow=0, state=4'h3 in one cycle -> err_sticky[1:0]=2'b11, err_count=1 (not 2), first_code=0.
- ch0 valid=1, ready=0, data=32'hA5A5_0000; next cycle data=32'hA5A5_0001 -> STABLE flag err_sticky[2]=1, first_code=2.
- TIMEOUT=8; ch0 stalled 20 cycles -> err_sticky[3] set after the 8th stall edge; err_count increments exactly once; a new stall after a handshake fires again (count=2).
- CNT_W=2; 5 violating cycles -> err_count=3; clear pulsed alone -> all outputs 0 next cycle; clear together with a violation -> err_count=1, first_valid=1.
- bypass=1 with bad state on all channels for 10 cycles -> no output changes; reset_n pulsed low mid-stall -> outputs 0 immediately, no spurious TIMEOUT after release.

Source files
------------

// File: rtl/tl_repeater_monitor.sv
// Protocol monitor for NUM_CH TileLink repeater channels.
// Violations set sticky flags, a saturating counter and a first-error capture.
module tl_repeater_monitor #(
   parameter int                  NUM_CH   = 2,
   parameter int                  STATE_W  = 4,
   parameter logic [STATE_W-1:0]  STATE_OK = {STATE_W{1'b1}},
   parameter int                  DATA_W   = 32,
   parameter int                  TIMEOUT  = 1024,
   parameter int                  CNT_W    = 8,
   localparam int                 CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        bypass,
   input  logic [NUM_CH-1:0]           ch_valid,
   input  logic [NUM_CH-1:0]           ch_ready,
   input  logic [NUM_CH-1:0]           ch_allow,
   input  logic [NUM_CH*STATE_W-1:0]   ch_state,
   input  logic [NUM_CH*DATA_W-1:0]    ch_data,
   input  logic                        clear,
   output logic [NUM_CH*4-1:0]         err_sticky,
   output logic                        err_any,
   output logic [CNT_W-1:0]            err_count,
   output logic                        first_valid,
   output logic [CH_W-1:0]             first_ch,
   output logic [1:0]                  first_code
);

   localparam int             SC_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(TIMEOUT);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [NUM_CH-1:0]             stalled_q, stalled_d;
   logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
   logic [NUM_CH-1:0][SC_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic [NUM_CH*4-1:0] viol;
   logic                any_viol;
   logic [CH_W-1:0]     pri_ch;
   logic [1:0]          pri_code;

   logic [NUM_CH*4-1:0] err_sticky_q, err_sticky_d;
   logic                err_any_q, err_any_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;
   logic                first_valid_q, first_valid_d;
   logic [CH_W-1:0]     first_ch_q, first_ch_d;
   logic [1:0]          first_code_q, first_code_d;

   // Per-channel violation terms and stall tracking; bypass masks checks and drops any stall in progress.
   always_comb begin
      viol        = '0;
      stalled_d   = '0;
      data_d      = '0;
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         viol[i*4 + 0] = !bypass && ch_valid[i] &&
                         (ch_state[i*STATE_W +: STATE_W] != STATE_OK);
         viol[i*4 + 1] = !bypass && ch_valid[i] && !ch_allow[i];
         viol[i*4 + 2] = !bypass && stalled_q[i] &&
                         (!ch_valid[i] || (ch_data[i*DATA_W +: DATA_W] != data_q[i]));
         viol[i*4 + 3] = !bypass && (TIMEOUT != 0) && (stall_cnt_q[i] == SC_LAST) &&
                         ch_valid[i] && !ch_ready[i];

         stalled_d[i] = !bypass && ch_valid[i] && !ch_ready[i];
         data_d[i]    = bypass ? '0 : ch_data[i*DATA_W +: DATA_W];

         // Counter parks at TIMEOUT so the starvation term fires once per episode.
         if (!stalled_d[i]) begin
            stall_cnt_d[i] = '0;
         end else if (stall_cnt_q[i] != SC_MAX) begin
            stall_cnt_d[i] = stall_cnt_q[i] + SC_W'(1);
         end
      end
   end

   // Lowest channel, then lowest code, wins the first-error capture.
   always_comb begin
      pri_ch   = '0;
      pri_code = '0;
      any_viol = |viol;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         for (int c = 3; c >= 0; c--) begin
            if (viol[i*4 + c]) begin
               pri_ch   = CH_W'(i);
               pri_code = 2'(c);
            end
         end
      end
   end

   // Clear coinciding with a violation keeps only the new event.
   always_comb begin
      err_sticky_d  = clear ? viol : (err_sticky_q | viol);
      err_any_d     = |err_sticky_d;
      err_count_d   = err_count_q;
      first_valid_d = first_valid_q;
      first_ch_d    = first_ch_q;
      first_code_d  = first_code_q;

      if (clear) begin
         err_count_d   = any_viol ? CNT_W'(1) : '0;
         first_valid_d = any_viol;
         first_ch_d    = pri_ch;
         first_code_d  = pri_code;
      end else begin
         if (any_viol && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
         if (!first_valid_q && any_viol) begin
            first_valid_d = 1'b1;
            first_ch_d    = pri_ch;
            first_code_d  = pri_code;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stalled_q     <= '0;
         data_q        <= '0;
         stall_cnt_q   <= '0;
         err_sticky_q  <= '0;
         err_any_q     <= 1'b0;
         err_count_q   <= '0;
         first_valid_q <= 1'b0;
         first_ch_q    <= '0;
         first_code_q  <= '0;
      end else begin
         stalled_q     <= stalled_d;
         data_q        <= data_d;
         stall_cnt_q   <= stall_cnt_d;
         err_sticky_q  <= err_sticky_d;
         err_any_q     <= err_any_d;
         err_count_q   <= err_count_d;
         first_valid_q <= first_valid_d;
         first_ch_q    <= first_ch_d;
         first_code_q  <= first_code_d;
      end
   end

   assign err_sticky  = err_sticky_q;
   assign err_any     = err_any_q;
   assign err_count   = err_count_q;
   assign first_valid = first_valid_q;
   assign first_ch    = first_ch_q;
   assign first_code  = first_code_q;

endmodule

// File: tb/tb_tl_repeater_monitor.sv
// Scoreboard bench for tl_repeater_monitor (NUM_CH=2, TIMEOUT=8, CNT_W=2).
// Stimulus pushes hand-computed expected outputs; a monitor pops one entry per clock.
module tb_tl_repeater_monitor;

   logic        clock;
   logic        reset_n;
   logic        bypass;
   logic [1:0]  ch_valid;
   logic [1:0]  ch_ready;
   logic [1:0]  ch_allow;
   logic [7:0]  ch_state;
   logic [63:0] ch_data;
   logic        clear;
   logic [7:0]  err_sticky;
   logic        err_any;
   logic [1:0]  err_count;
   logic        first_valid;
   logic [0:0]  first_ch;
   logic [1:0]  first_code;

   int errors = 0;
   int checks = 0;

   logic [14:0] expQ[$];
   string       nameQ[$];

   tl_repeater_monitor #(
      .NUM_CH(2), .STATE_W(4), .STATE_OK(4'hF), .DATA_W(32), .TIMEOUT(8), .CNT_W(2)
   ) dut (
      .clock(clock), .reset_n(reset_n), .bypass(bypass),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_allow(ch_allow),
      .ch_state(ch_state), .ch_data(ch_data), .clear(clear),
      .err_sticky(err_sticky), .err_any(err_any), .err_count(err_count),
      .first_valid(first_valid), .first_ch(first_ch), .first_code(first_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected output word: {sticky, any, count, first_valid, first_ch, first_code}.
   function automatic logic [14:0] mk(input logic [7:0] st, input logic [1:0] cnt,
                                      input logic fv, input logic fch, input logic [1:0] fc);
      return {st, |st, cnt, fv, fch, fc};
   endfunction

   task automatic checkOutput(input string nm, input logic [14:0] expv);
      logic [14:0] act;
      act = {err_sticky, err_any, err_count, first_valid, first_ch, first_code};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] r, input logic [1:0] a,
                                input logic [7:0] st, input logic [63:0] d,
                                input logic byp, input logic clr,
                                input logic [14:0] expv, input string nm);
      @(negedge clock);
      ch_valid = v;
      ch_ready = r;
      ch_allow = a;
      ch_state = st;
      ch_data  = d;
      bypass   = byp;
      clear    = clr;
      expQ.push_back(expv);
      nameQ.push_back(nm);
   endtask

   always @(posedge clock) begin
      #1;
      if (expQ.size() > 0) begin
         checkOutput(nameQ.pop_front(), expQ.pop_front());
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   localparam logic [63:0] DSTALL = 64'h0000_0000_1234_5678;

   initial begin
      logic [14:0] h;
      reset_n  = 1'b0;
      bypass   = 1'b0;
      ch_valid = 2'b00;
      ch_ready = 2'b00;
      ch_allow = 2'b11;
      ch_state = 8'hFF;
      ch_data  = '0;
      clear    = 1'b0;
      #3;
      checkOutput("reset_state", 15'h0);
      @(negedge clock);
      reset_n = 1'b1;

      // Bad state on channel 1
      applyStimulus(2'b10, 2'b11, 2'b11, 8'hEF, 64'h0, 0, 0, mk(8'h10, 2'd1, 1, 1, 2'd0), "state_ch1");
      applyStimulus(2'b00, 2'b11, 2'b11, 8'hFF, 64'h0, 0, 0, mk(8'h10, 2'd1, 1, 1, 2'd0), "state_ch1_hold");
      applyStimulus(2'b00, 2'b11, 2'b11, 8'hFF, 64'h0, 0, 1, 15'h0, "clear_alone_a");

      // State and permit together on channel 0 count as one cycle
      applyStimulus(2'b01, 2'b11, 2'b10, 8'hF3, 64'h0, 0, 0, mk(8'h03, 2'd1, 1, 0, 2'd0), "state_permit_ch0");
      applyStimulus(2'b00, 2'b11, 2'b11, 8'hFF, 64'h0, 0, 1, 15'h0, "clear_b");

      // Payload changes during a stall
      applyStimulus(2'b01, 2'b00, 2'b11, 8'hFF, 64'hA5A5_0000, 0, 0, 15'h0, "stable_stall");
      applyStimulus(2'b01, 2'b00, 2'b11, 8'hFF, 64'hA5A5_0001, 0, 0, mk(8'h04, 2'd1, 1, 0, 2'd2), "stable_change");
      applyStimulus(2'b01, 2'b01, 2'b11, 8'hFF, 64'hA5A5_0001, 0, 0, mk(8'h04, 2'd1, 1, 0, 2'd2), "stable_handshake");
      applyStimulus(2'b00, 2'b11, 2'b11, 8'hFF, 64'h0, 0, 1, 15'h0, "clear_c");

      // Long stall fires the starvation error once, a fresh stall fires again
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(2'b01, 2'b00, 2'b11, 8'hFF, DSTALL, 0, 0,
                       (k < 8) ? 15'h0 : mk(8'h08, 2'd1, 1, 0, 2'd3), $sformatf("timeout_stall%0d", k));
      end
      applyStimulus(2'b01, 2'b01, 2'b11, 8'hFF, DSTALL, 0, 0, mk(8'h08, 2'd1, 1, 0, 2'd3), "timeout_handshake");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(2'b01, 2'b00, 2'b11, 8'hFF, DSTALL, 0, 0,
                       (k < 8) ? mk(8'h08, 2'd1, 1, 0, 2'd3) : mk(8'h08, 2'd2, 1, 0, 2'd3),
                       $sformatf("timeout_restall%0d", k));
      end
      applyStimulus(2'b01, 2'b01, 2'b11, 8'hFF, DSTALL, 0, 1, 15'h0, "clear_d");

      // Counter saturation and clear/violation interaction
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(2'b10, 2'b11, 2'b11, 8'hEF, 64'h0, 0, 0,
                       mk(8'h10, (k < 3) ? 2'(k) : 2'd3, 1, 1, 2'd0), $sformatf("saturate%0d", k));
      end
      applyStimulus(2'b00, 2'b11, 2'b11, 8'hFF, 64'h0, 0, 1, 15'h0, "clear_alone_e");
      applyStimulus(2'b10, 2'b11, 2'b11, 8'hEF, 64'h0, 0, 0, mk(8'h10, 2'd1, 1, 1, 2'd0), "pre_clear_viol");
      applyStimulus(2'b01, 2'b11, 2'b10, 8'hFF, 64'h0, 0, 1, mk(8'h02, 2'd1, 1, 0, 2'd1), "clear_with_viol");
      applyStimulus(2'b00, 2'b11, 2'b11, 8'hFF, 64'h0, 0, 1, 15'h0, "clear_f");

      // Bypass masks everything and drops stall tracking
      h = mk(8'h10, 2'd1, 1, 1, 2'd0);
      applyStimulus(2'b10, 2'b11, 2'b11, 8'hEF, 64'h0, 0, 0, h, "pre_bypass_viol");
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(2'b11, 2'b00, 2'b00, 8'h00, 64'(k), 1, 0, h, $sformatf("bypass%0d", k));
      end
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(2'b01, 2'b00, 2'b11, 8'hFF, 64'h0000_0000_CAFE_0001, 0, 0, h,
                       $sformatf("post_bypass_stall%0d", k));
      end

      // Reset in the middle of a stall
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkOutput("reset_async", 15'h0);
      @(posedge clock);
      @(posedge clock);
      #2;
      checkOutput("reset_held", 15'h0);
      reset_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(2'b01, 2'b00, 2'b11, 8'hFF, 64'h0000_0000_CAFE_0001, 0, 0,
                       (k < 8) ? 15'h0 : mk(8'h08, 2'd1, 1, 0, 2'd3), $sformatf("post_reset_stall%0d", k));
      end

      for (int k = 0; k < 5 && expQ.size() > 0; k++) begin
         @(negedge clock);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d entries pending, expected 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
